// File: rtl/div_unit_if.sv
// div_unit_if: start/operand/result bundle between the control FSM and the divider
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (output start, a, b, input busy, done, hi, lo, div_zero);
    modport slave  (input start, a, b, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/div_unit.sv
// div_unit: multicycle restoring signed divider, quotient to lo and remainder to hi
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      reset_i,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d, zero_q, zero_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [WIDTH:0]   rem_sh, trial;
    // trial subtraction kept one bit wider so its MSB is the borrow
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                sign_a_d = bus.a[WIDTH-1];
                sign_b_d = bus.b[WIDTH-1];
                quo_d    = bus.a[WIDTH-1] ? -bus.a : bus.a;
                dvs_d    = bus.b[WIDTH-1] ? -bus.b : bus.b;
                rem_d    = '0;
                cnt_d    = '0;
                zero_d   = (bus.b == '0);
                busy_d   = 1'b1;
                state_d  = (bus.b == '0) ? FINISH : RUN;
            end
            RUN: begin
                rem_d   = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FINISH : RUN;
            end
            FINISH: begin
                lo_d    = zero_q ? lo_q : ((sign_a_q ^ sign_b_q) ? -quo_q : quo_q);
                hi_d    = zero_q ? hi_q : (sign_a_q ? -rem_q : rem_q);
                done_d  = 1'b1;
                dz_d    = zero_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = dz_q;
endmodule
